// File: rtl/dmem_responder.sv
// Data-memory responder for the core load/store port.
// One request in flight, programmable wait states, sized stores and loads.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic          uns_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic          resp_err_q;
  logic [31:0]   resp_rdata_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [31:0]   wmerge_d;
  logic [31:0]   ld_d;
  logic          err_d;
  logic          commit;
  logic [4:0]    bsh;
  logic [4:0]    hsh;
  logic [7:0]    bsel;
  logic [15:0]   hsel;

  always_comb begin
    idx    = addr_q[AW+1:2];
    word   = mem_q[idx];
    bsh    = {addr_q[1:0], 3'b000};
    hsh    = {addr_q[1], 4'b0000};
    bsel   = word[bsh +: 8];
    hsel   = word[hsh +: 16];
    err_d  = (size_q == 2'b11)
          || (size_q == 2'b01 && addr_q[0])
          || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
          || (addr_q[31:2] >= 30'(DEPTH_WORDS));
    wmerge_d = word;
    ld_d     = '0;
    unique case (size_q)
      2'b00: begin
        wmerge_d[bsh +: 8] = wdata_q[7:0];
        ld_d = uns_q ? {24'h0, bsel} : {{24{bsel[7]}}, bsel};
      end
      2'b01: begin
        wmerge_d[hsh +: 16] = wdata_q[15:0];
        ld_d = uns_q ? {16'h0, hsel} : {{16{hsel[15]}}, hsel};
      end
      2'b10: begin
        wmerge_d = wdata_q;
        ld_d     = word;
      end
      default: begin
        wmerge_d = word;
        ld_d     = '0;
      end
    endcase
    commit = (state_q == S_WAIT) && (cnt_q == '0);
  end

  // Stores commit on the edge that enters RESP; a reset before then drops them.
  always_ff @(posedge clock) begin
    if (reset && commit && we_q && !err_d)
      mem_q[idx] <= wmerge_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            size_q      <= req_size;
            uns_q       <= req_unsigned;
            wdata_q     <= req_wdata;
            cnt_q       <= CW'(WAIT_CYCLES);
            req_ready_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_d;
            resp_rdata_q <= (err_d || we_q) ? 32'h0 : ld_d;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
